// File: rtl/alu_mc_if.sv
// Request/response bundle for the multi-cycle ALU.
// The master drives requests and out_ready. The slave returns in_ready, out_valid and result.
interface alu_mc_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic            funct7_5;
  logic            is_reg;
  logic            is_mdiv;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] imm;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, funct3, funct7_5, is_reg, is_mdiv, rs1, rs2, imm, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, funct3, funct7_5, is_reg, is_mdiv, rs1, rs2, imm, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle RV integer ALU: single-cycle base ops, bit-serial shifts,
// shift-add multiply and restoring divide, with a valid/ready handshake on each side.
module alu_mc #(
  parameter int XLEN        = 32,
  parameter int ENABLE_MDIV = 1
) (
  input logic     clk,
  input logic     rst,
  alu_mc_if.slave bus
);
  localparam int LOGX = $clog2(XLEN);
  localparam int CW   = LOGX + 1;

  typedef enum logic [2:0] {IDLE, SHIFT, MUL, DIV, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [XLEN-1:0]     opa_q, opa_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [2:0]          f3_q, f3_d;
  logic                sra_q, sra_d;
  logic                negq_q, negq_d;
  logic                negr_q, negr_d;

  logic [XLEN-1:0]        op2, alu_res, a_mag, b_mag, sh_res;
  logic signed [XLEN-1:0] rs1_s, op2_s;
  logic [CW-1:0]          shamt, cnt_dec;
  logic                   mdiv, is_sub, is_shift, sa, sb, div_zero, div_ovf, last;
  logic [XLEN:0]          mul_sum, rem_sh, rem_diff;
  logic [2*XLEN-1:0]      mul_nxt, div_nxt, prod;

  function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cneg2(input logic [2*XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  // Request decode: operand select, base-op result and M-op operand magnitudes
  always_comb begin
    op2      = bus.is_reg ? bus.rs2 : bus.imm;
    rs1_s    = bus.rs1;
    op2_s    = op2;
    mdiv     = (ENABLE_MDIV != 0) && bus.is_mdiv;
    is_sub   = bus.is_reg && bus.funct7_5 && (bus.funct3 == 3'b000);
    is_shift = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b101);
    shamt    = CW'(op2[LOGX-1:0]);

    case (bus.funct3)
      3'b000:  alu_res = is_sub ? (bus.rs1 - op2) : (bus.rs1 + op2);
      3'b010:  alu_res = {{(XLEN-1){1'b0}}, (rs1_s < op2_s)};
      3'b011:  alu_res = {{(XLEN-1){1'b0}}, (bus.rs1 < op2)};
      3'b100:  alu_res = bus.rs1 ^ op2;
      3'b110:  alu_res = bus.rs1 | op2;
      3'b111:  alu_res = bus.rs1 & op2;
      default: alu_res = bus.rs1;
    endcase

    // Multiply and divide run on magnitudes; signs are reapplied at the end
    if (bus.funct3[2]) begin
      sa = !bus.funct3[0] && bus.rs1[XLEN-1];
      sb = !bus.funct3[0] && bus.rs2[XLEN-1];
    end else begin
      sa = ((bus.funct3 == 3'b001) || (bus.funct3 == 3'b010)) && bus.rs1[XLEN-1];
      sb = (bus.funct3 == 3'b001) && bus.rs2[XLEN-1];
    end
    a_mag    = cneg(bus.rs1, sa);
    b_mag    = cneg(bus.rs2, sb);
    div_zero = (bus.rs2 == '0);
    div_ovf  = !bus.funct3[0] && (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2 == '1);
  end

  // Per-iteration datapath for the shift, multiply and divide states
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opa_q} : '0);
    mul_nxt  = {mul_sum, acc_q[XLEN-1:1]};
    prod     = cneg2(mul_nxt, negq_q);
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_diff = rem_sh - {1'b0, opa_q};
    div_nxt  = {(rem_diff[XLEN] ? rem_sh[XLEN-1:0] : rem_diff[XLEN-1:0]),
                acc_q[XLEN-2:0], !rem_diff[XLEN]};
    sh_res   = (f3_q == 3'b001) ? {opa_q[XLEN-2:0], 1'b0}
                                : {sra_q & opa_q[XLEN-1], opa_q[XLEN-1:1]};
    // A zero count also terminates, so the counter can never wrap
    last     = (cnt_q <= CW'(1));
    cnt_dec  = (cnt_q != '0) ? (cnt_q - CW'(1)) : cnt_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    opa_d    = opa_q;
    acc_d    = acc_q;
    f3_d     = f3_q;
    sra_d    = sra_q;
    negq_d   = negq_q;
    negr_d   = negr_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          f3_d  = bus.funct3;
          sra_d = bus.funct7_5;
          if (mdiv) begin
            negq_d = sa ^ sb;
            negr_d = sa;
            opa_d  = b_mag;
            acc_d  = {{XLEN{1'b0}}, a_mag};
            cnt_d  = CW'(XLEN);
            if (!bus.funct3[2]) begin
              state_d = MUL;
            end else if (div_zero) begin
              result_d = bus.funct3[1] ? bus.rs1 : '1;
              state_d  = DONE;
            end else if (div_ovf) begin
              result_d = bus.funct3[1] ? '0 : bus.rs1;
              state_d  = DONE;
            end else begin
              state_d = DIV;
            end
          end else if (is_shift && (shamt != '0)) begin
            opa_d   = bus.rs1;
            cnt_d   = shamt;
            state_d = SHIFT;
          end else begin
            result_d = alu_res;
            state_d  = DONE;
          end
        end
      end
      SHIFT: begin
        opa_d = sh_res;
        cnt_d = cnt_dec;
        if (last) begin
          result_d = sh_res;
          state_d  = DONE;
        end
      end
      MUL: begin
        acc_d = mul_nxt;
        cnt_d = cnt_dec;
        if (last) begin
          result_d = (f3_q == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          state_d  = DONE;
        end
      end
      DIV: begin
        acc_d = div_nxt;
        cnt_d = cnt_dec;
        if (last) begin
          result_d = f3_q[1] ? cneg(div_nxt[2*XLEN-1:XLEN], negr_q)
                             : cneg(div_nxt[XLEN-1:0], negq_q);
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      opa_q    <= '0;
      acc_q    <= '0;
      f3_q     <= '0;
      sra_q    <= 1'b0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      opa_q    <= opa_d;
      acc_q    <= acc_d;
      f3_q     <= f3_d;
      sra_q    <= sra_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE) && !rst;
  assign bus.result    = result_q;

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand/result width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter ENABLE_MDIV, default 1: 1 = M-extension ops enabled; 0 = is_mdiv ignored, ops decode as base ops.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: request valid.
REQ-006 SHALL have port in_ready, output, 1 bit: unit can accept a request.
REQ-007 SHALL have port funct3, input, 3 bits: RV funct3.
REQ-008 SHALL have port funct7_5, input, 1 bit: instr[30] (SUB/SRA select).
REQ-009 SHALL have port is_reg, input, 1 bit: 1 = R-type (operand2 = rs2); 0 = I-type (operand2 = imm).
REQ-010 SHALL have port is_mdiv, input, 1 bit: R-type with funct7 = 0000001.
REQ-011 SHALL have ports rs1, rs2, imm, input, XLEN bits each: operands, with imm already sign-extended.
REQ-012 SHALL have port out_valid, output, 1 bit: result valid.
REQ-013 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-014 SHALL have port result, output, XLEN bits: registered result.

Function
REQ-015 SHALL accept a request on the edge where in_valid && in_ready; operands and controls are captured then, and later input changes are ignored.
REQ-016 SHALL implement FSM states IDLE, SHIFT, MUL, DIV, DONE; in_ready = 1 only in IDLE with rst low.
REQ-017 SHALL go from IDLE on accept to: DONE for add/sub/slt/sltu/xor/or/and and special-case div; SHIFT for shifts with shamt != 0; MUL or DIV for M ops.
REQ-018 SHALL subtract only when is_reg && funct7_5 && funct3 = 000; immediate ADDI ignores funct7_5.
REQ-019 SHALL take shamt from operand2[log2(XLEN)-1:0], shifting 1 bit per cycle; SRA/SRAI when funct3 = 101 && funct7_5.
REQ-020 SHALL make a shift with shamt = 0 go directly to DONE, returning rs1 unchanged.
REQ-021 SHALL return SLT/SLTU results zero-extended to 0 or 1.
REQ-022 SHALL produce, for funct3 000-011 in MUL: MUL = low XLEN bits; MULH = signed x signed high bits; MULHSU = signed rs1 x unsigned rs2 high bits; MULHU = unsigned high bits; iterative over XLEN cycles.
REQ-023 SHALL produce, for funct3 100-111 in DIV: DIV/DIVU/REM/REMU via restoring division over XLEN cycles; remainder sign = dividend sign; quotient truncated toward zero.
REQ-024 SHALL handle a divisor of 0 with no iteration: quotient all ones, remainder = dividend.
REQ-025 SHALL handle signed overflow (most-negative / -1) with no iteration: quotient = dividend, remainder 0.
REQ-026 SHALL give latency from accept edge to out_valid high of: 1 cycle for single-cycle ops and special-case div; 1+shamt for shifts; 1+XLEN for MUL/DIV.
REQ-027 SHALL in DONE hold out_valid = 1 and result stable until out_ready, then return to IDLE on the edge where out_valid && out_ready.
REQ-028 SHALL keep in_ready low in DONE, so no same-cycle accept-and-complete; minimum issue interval 2 cycles.
REQ-029 SHALL use an iteration counter of log2(XLEN)+1 bits that never wraps; the terminal count forces DONE.

Reset
REQ-030 SHALL, while rst is high, force state = IDLE, out_valid = 0, result = 0, internal operand/accumulator registers = 0, and in_ready = 0.
REQ-031 SHALL on rst asserted mid-operation (SHIFT/MUL/DIV/DONE) abort the operation with no out_valid pulse; in_ready is 1 the first cycle after rst falls.

Verification
REQ-032 SHALL cover ADDI: rs1 = 5, imm = 0xFFFFFFFD, is_reg = 0, funct7_5 = 1 -> result 0x00000002, out_valid 1 cycle after accept.
REQ-033 SHALL cover SRA: rs1 = 0x80000000, rs2 = 4, funct3 = 101, funct7_5 = 1, is_reg = 1 -> 0xF8000000 after 5 cycles; same with rs2 = 0 -> 0x80000000 after 1 cycle.
REQ-034 SHALL cover multiply: rs1 = 0xFFFFFFFF, rs2 = 2 -> MULH 0xFFFFFFFF, MULHU 0x00000001, MUL 0xFFFFFFFE, each after 33 cycles.
REQ-035 SHALL cover division corners: DIV 7/0 -> 0xFFFFFFFF and REM 7/0 -> 7, each after 1 cycle; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -7/2 -> 0xFFFFFFFF after 33 cycles.
REQ-036 SHALL cover backpressure: out_ready held low 3 cycles in DONE -> result stable, in_ready 0; handshake -> in_ready 1 the next cycle.
REQ-037 SHALL cover reset mid-DIV: rst pulsed at iteration 10 -> no out_valid; a new ADD accepted the cycle after reset completes correctly.
